// File: rtl/dsp_arb_pkg.sv
// Shared definitions for the round-robin multiply-add/sub arbiter.
// Holds the default operand widths, the op encodings and the width of the
// optional per-requester grant counters (enabled by DSP_ARB_STATS_EN),
// plus the saturating increment used by those counters.
package dsp_arb_pkg;

  localparam int DEF_A_W = 26;
  localparam int DEF_B_W = 17;
  localparam int DEF_C_W = 48;

  localparam logic OP_MULADD = 1'b0;
  localparam logic OP_MULSUB = 1'b1;

  localparam int STAT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] r;
    if (v == {STAT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_muladd_core.sv
// Shared arithmetic slice: res = (a*b) + c or (a*b) - c, modulo 2^C_W.
// The product is A_W+B_W bits and zero-extended to C_W before the add/sub.
// PIPE_LAT register stages, no reset on any data register so the whole
// thing can be absorbed into a single DSP48E2.
// Ports:
//   clk  clock
//   a    multiplicand [A_W]
//   b    multiplier   [B_W]
//   c    addend       [C_W]
//   op   0 = add, 1 = subtract
//   res  result after PIPE_LAT cycles [C_W]
module dsp_muladd_core
  import dsp_arb_pkg::*;
#(
  parameter int A_W      = DEF_A_W,
  parameter int B_W      = DEF_B_W,
  parameter int C_W      = DEF_C_W,
  parameter int PIPE_LAT = 1
) (
  input  logic           clk,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] c,
  input  logic           op,
  output logic [C_W-1:0] res
);

  logic [A_W+B_W-1:0] prod;
  logic [C_W-1:0]     prod_ext;
  logic [C_W-1:0]     sum;
  logic [C_W-1:0]     pipe [PIPE_LAT];

  // Unsigned product, widened to the accumulator width, then add or subtract.
  always_comb begin
    prod     = a * b;
    prod_ext = C_W'(prod);
    if (op == OP_MULSUB) begin
      sum = prod_ext - c;
    end else begin
      sum = prod_ext + c;
    end
  end

  // Data pipeline; stage 0 captures the arithmetic result.
  always_ff @(posedge clk) begin
    pipe[0] <= sum;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign res = pipe[PIPE_LAT-1];

endmodule

// File: rtl/dsp_muladd_rr_arbiter.sv
// Round-robin front end sharing one multiply-add/sub slice among NUM_REQ
// requesters. One request is issued per cycle at most; each result comes back
// PIPE_LAT cycles after acceptance tagged with the requester index.
// Optional feature macro: DSP_ARB_STATS_EN adds per-requester 32-bit
// saturating grant counters on port stat_grant_cnt.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid/ready  per-requester handshake, req_ready is a one-hot grant
//   req_op/a/b/c     packed per-requester operands, requester i at [i*W +: W]
//   res_valid        one-cycle pulse per accepted request
//   res_id/res_data  requester index and result (data is zero when not valid)
//   busy             any accepted request still in flight
//   stat_grant_cnt   (DSP_ARB_STATS_EN only) packed grant counters
module dsp_muladd_rr_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int A_W      = DEF_A_W,
  parameter int B_W      = DEF_B_W,
  parameter int C_W      = DEF_C_W,
  parameter int PIPE_LAT = 1,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  input  logic [NUM_REQ*C_W-1:0] req_c,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [C_W-1:0]         res_data,
  output logic                   busy
`ifdef DSP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grant_cnt
`endif
);

  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                issue;
  logic                hit;
  int unsigned         scan_idx;
  logic [ID_W-1:0]     scan_id;

  logic [A_W-1:0]      sel_a;
  logic [B_W-1:0]      sel_b;
  logic [C_W-1:0]      sel_c;
  logic                sel_op;
  logic [C_W-1:0]      core_res;

  logic [PIPE_LAT-1:0] tag_valid;
  logic [ID_W-1:0]     tag_id [PIPE_LAT];

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant    = {NUM_REQ{1'b0}};
    grant_id = {ID_W{1'b0}};
    issue    = 1'b0;
    hit      = 1'b0;
    scan_idx = 0;
    scan_id  = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx       = (int'(rr_ptr) + k) % NUM_REQ;
      scan_id        = ID_W'(scan_idx);
      hit            = !issue && req_valid[scan_id];
      grant[scan_id] = grant[scan_id] | hit;
      grant_id       = hit ? scan_id : grant_id;
      issue          = issue | hit;
    end
  end

  assign req_ready = grant;

  // Operand select for the granted requester (index 0 when idle; unused then).
  always_comb begin
    sel_a  = {A_W{1'b0}};
    sel_b  = {B_W{1'b0}};
    sel_c  = {C_W{1'b0}};
    sel_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a  = (grant_id == ID_W'(i)) ? req_a[i*A_W +: A_W] : sel_a;
      sel_b  = (grant_id == ID_W'(i)) ? req_b[i*B_W +: B_W] : sel_b;
      sel_c  = (grant_id == ID_W'(i)) ? req_c[i*C_W +: C_W] : sel_c;
      sel_op = (grant_id == ID_W'(i)) ? req_op[i] : sel_op;
    end
  end

  // Priority pointer moves to the requester after the one just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= {ID_W{1'b0}};
    end else if (issue) begin
      if (grant_id == ID_W'(NUM_REQ - 1)) begin
        rr_ptr <= {ID_W{1'b0}};
      end else begin
        rr_ptr <= grant_id + ID_W'(1);
      end
    end
  end

  dsp_muladd_core #(
    .A_W      (A_W),
    .B_W      (B_W),
    .C_W      (C_W),
    .PIPE_LAT (PIPE_LAT)
  ) u_core (
    .clk (clk),
    .a   (sel_a),
    .b   (sel_b),
    .c   (sel_c),
    .op  (sel_op),
    .res (core_res)
  );

  // Tag pipeline tracking {valid, id} in lockstep with the data stages.
  // Reset drops every in-flight tag, so those results are never emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= {PIPE_LAT{1'b0}};
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_id[i] <= {ID_W{1'b0}};
      end
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= grant_id;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign res_valid = tag_valid[PIPE_LAT-1];
  assign res_id    = tag_id[PIPE_LAT-1];
  // Core data registers are not reset; gating with the tag valid keeps the
  // output at zero after reset and between results.
  assign res_data  = core_res & {C_W{tag_valid[PIPE_LAT-1]}};
  assign busy      = |tag_valid;

`ifdef DSP_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  // Per-requester saturating grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_cnt[i] <= {STAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          stat_cnt[i] <= sat_inc(stat_cnt[i]);
        end
      end
    end
  end

  // Flatten the counter array onto the packed output port.
  always_comb begin
    stat_grant_cnt = {(NUM_REQ*STAT_W){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grant_cnt[i*STAT_W +: STAT_W] = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_dsp_muladd_rr_arbiter.sv
// Scoreboard bench for dsp_muladd_rr_arbiter. Two instances share the same
// stimulus: one with a 1-stage datapath and one with a 3-stage datapath.
module tb_dsp_muladd_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_op;
  logic [103:0] req_a;
  logic [67:0]  req_b;
  logic [191:0] req_c;

  logic [3:0]   ready1, ready3;
  logic         res_valid1, res_valid3;
  logic [1:0]   res_id1, res_id3;
  logic [47:0]  res_data1, res_data3;
  logic         busy1, busy3;
`ifdef DSP_ARB_STATS_EN
  logic [127:0] stats1, stats3;
`endif

  int total = 0;
  int bad   = 0;

  logic [49:0] q1[$];
  logic [49:0] q3[$];
  logic [47:0] exp_d [4];
  int          exp_cnt [4];
  logic [2:0]  hist;

  always #5 clk = ~clk;

  dsp_muladd_rr_arbiter #(.NUM_REQ(4), .PIPE_LAT(1)) u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (ready1), .req_op (req_op),
    .req_a (req_a), .req_b (req_b), .req_c (req_c),
    .res_valid (res_valid1), .res_id (res_id1), .res_data (res_data1),
    .busy (busy1)
`ifdef DSP_ARB_STATS_EN
    , .stat_grant_cnt (stats1)
`endif
  );

  dsp_muladd_rr_arbiter #(.NUM_REQ(4), .PIPE_LAT(3)) u_dut3 (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (ready3), .req_op (req_op),
    .req_a (req_a), .req_b (req_b), .req_c (req_c),
    .res_valid (res_valid3), .res_id (res_id3), .res_data (res_data3),
    .busy (busy3)
`ifdef DSP_ARB_STATS_EN
    , .stat_grant_cnt (stats3)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [25:0] a, input logic [16:0] b,
                         input logic [47:0] c, input logic op, input logic [47:0] e);
    req_a[i*26 +: 26] = a;
    req_b[i*17 +: 17] = b;
    req_c[i*48 +: 48] = c;
    req_op[i]         = op;
    exp_d[i]          = e;
  endtask

  // One cycle starting and ending at a falling edge.
  task automatic step(input logic [3:0] v, input logic [3:0] exp_g, input bit push3);
    logic [1:0] id;
    chk("busy1", {63'd0, busy1}, {63'd0, hist[0]});
    chk("busy3", {63'd0, busy3}, {63'd0, |hist});
    req_valid = v;
    #1;
    chk("ready1", {60'd0, ready1}, {60'd0, exp_g});
    chk("ready3", {60'd0, ready3}, {60'd0, exp_g});
    if (exp_g != 4'b0000) begin
      id = 2'd0;
      for (int i = 0; i < 4; i++) begin
        if (exp_g[i]) id = 2'(i);
      end
      q1.push_back({id, exp_d[id]});
      if (push3) q3.push_back({id, exp_d[id]});
      exp_cnt[id]++;
    end
    hist = {hist[1:0], exp_g != 4'b0000};
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid1"}, {63'd0, res_valid1}, 64'd0);
    chk({tag, "_id1"},    {62'd0, res_id1},    64'd0);
    chk({tag, "_data1"},  {16'd0, res_data1},  64'd0);
    chk({tag, "_busy1"},  {63'd0, busy1},      64'd0);
    chk({tag, "_valid3"}, {63'd0, res_valid3}, 64'd0);
    chk({tag, "_id3"},    {62'd0, res_id3},    64'd0);
    chk({tag, "_data3"},  {16'd0, res_data3},  64'd0);
    chk({tag, "_busy3"},  {63'd0, busy3},      64'd0);
  endtask

  task automatic check_stats();
`ifdef DSP_ARB_STATS_EN
    for (int i = 0; i < 4; i++) begin
      chk("stat1", {32'd0, stats1[i*32 +: 32]}, 64'(exp_cnt[i]));
      chk("stat3", {32'd0, stats3[i*32 +: 32]}, 64'(exp_cnt[i]));
    end
`endif
  endtask

  task automatic check_drained();
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q3_empty", 64'(q3.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    rst  = 1'b0;
    hist = 3'b000;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
  endtask

  // Monitor for the 1-stage instance.
  always @(posedge clk) begin
    logic [49:0] e;
    #1;
    if (res_valid1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res1_unexpected: got id %0d data %0h, expected no result", res_id1, res_data1);
      end else begin
        e = q1.pop_front();
        chk("res1_id",   {62'd0, res_id1},   {62'd0, e[49:48]});
        chk("res1_data", {16'd0, res_data1}, {16'd0, e[47:0]});
      end
    end
  end

  // Monitor for the 3-stage instance.
  always @(posedge clk) begin
    logic [49:0] e;
    #1;
    if (res_valid3) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res3_unexpected: got id %0d data %0h, expected no result", res_id3, res_data3);
      end else begin
        e = q3.pop_front();
        chk("res3_id",   {62'd0, res_id3},   {62'd0, e[49:48]});
        chk("res3_data", {16'd0, res_data3}, {16'd0, e[47:0]});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_op    = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    hist      = 3'b000;
    for (int i = 0; i < 4; i++) begin
      exp_d[i]   = 48'd0;
      exp_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_ready1", {60'd0, ready1}, 64'd0);
    check_stats();
    rst = 1'b0;

    // Single request: 3*5+7 = 22.
    set_req(0, 26'd3, 17'd5, 48'd7, 1'b0, 48'd22);
    step(4'b0001, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    // Subtract wrap: 1*1-2 = -1 mod 2^48.
    set_req(1, 26'd1, 17'd1, 48'd2, 1'b1, 48'hFFFF_FFFF_FFFF);
    step(4'b0010, 4'b0010, 1'b1);
    // Max operands: product 0x7FFFBFE0001, plus 2^48-1 wraps to product-1.
    set_req(2, 26'h3FF_FFFF, 17'h1_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0, 48'h07FF_FBFE_0000);
    step(4'b0100, 4'b0100, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, 1'b1);
    check_drained();
    check_stats();

    // Fairness from reset: all four valid, strict rotation.
    pulse_reset();
    set_req(0, 26'd1, 17'd2, 48'd10, 1'b0, 48'd12);
    set_req(1, 26'd2, 17'd2, 48'd10, 1'b0, 48'd14);
    set_req(2, 26'd3, 17'd2, 48'd10, 1'b0, 48'd16);
    set_req(3, 26'd4, 17'd2, 48'd10, 1'b0, 48'd18);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b0001 << (k % 4), 1'b1);
    end
    // Sparse: move pointer to 2, then only requesters 1 and 3 compete.
    step(4'b0010, 4'b0010, 1'b1);
    step(4'b1010, 4'b1000, 1'b1);
    step(4'b1010, 4'b0010, 1'b1);
    step(4'b1010, 4'b1000, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, 1'b1);
    check_drained();
    check_stats();

    // Reset while the 3-stage instance has two requests in flight.
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    pulse_reset();
    check_idle_outputs("flush");
    check_stats();
    repeat (4) step(4'b0000, 4'b0000, 1'b1);
    // First grant after reset goes to the lowest valid index.
    step(4'b1100, 4'b0100, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, 1'b1);
    check_drained();
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
